// File: rtl/order_pkg.sv
// Shared order definitions for the ITCH-style encoder and parser: field enums,
// message geometry, type characters and space-padded ASCII stock identifiers.
package order_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned NUM_WORDS = 9;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {
    ORD_ADD     = 2'd0,
    ORD_CANCEL  = 2'd1,
    ORD_EXECUTE = 2'd2,
    ORD_ILLEGAL = 2'd3
  } order_t;

  typedef enum logic {
    TRADE_BUY  = 1'b0,
    TRADE_SELL = 1'b1
  } trade_t;

  typedef enum logic [1:0] {
    STK_AAPL  = 2'd0,
    STK_AMZN  = 2'd1,
    STK_GOOGL = 2'd2,
    STK_MSFT  = 2'd3
  } stock_t;

  localparam logic [7:0] CHAR_ADD     = 8'h41;
  localparam logic [7:0] CHAR_CANCEL  = 8'h44;
  localparam logic [7:0] CHAR_EXECUTE = 8'h45;

  localparam logic [63:0] ID_AAPL  = 64'h4141504C20202020;
  localparam logic [63:0] ID_AMZN  = 64'h414D5A4E20202020;
  localparam logic [63:0] ID_GOOGL = 64'h474F4F474C202020;
  localparam logic [63:0] ID_MSFT  = 64'h4D53465420202020;

  typedef struct packed {
    order_t      order_type;
    stock_t      symbol;
    trade_t      side;
    logic [31:0] order_id;
    logic [31:0] price;
    logic [31:0] quantity;
    logic [31:0] time_stamp;
    logic [15:0] locate;
    logic [15:0] tracking;
  } order_fields_t;

  typedef logic [NUM_WORDS-1:0][REG_WIDTH-1:0] msg_words_t;

  function automatic logic [63:0] stock_id(input stock_t s);
    unique case (s)
      STK_AAPL:  return ID_AAPL;
      STK_AMZN:  return ID_AMZN;
      STK_GOOGL: return ID_GOOGL;
      default:   return ID_MSFT;
    endcase
  endfunction

  function automatic logic [7:0] type_char(input order_t t);
    unique case (t)
      ORD_ADD:     return CHAR_ADD;
      ORD_CANCEL:  return CHAR_CANCEL;
      ORD_EXECUTE: return CHAR_EXECUTE;
      default:     return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/order_msg_packer.sv
// Combinational packing of one decoded order into the nine-word message layout.
module order_msg_packer
  import order_pkg::*;
(
  input  order_fields_t i_fields,
  output msg_words_t    o_words
);

  logic [63:0] sym_c;

  always_comb begin
    sym_c   = stock_id(i_fields.symbol);
    o_words = '0;

    o_words[0] = {i_fields.tracking[7:0], i_fields.locate, type_char(i_fields.order_type)};
    o_words[1] = {i_fields.time_stamp[23:0], i_fields.tracking[15:8]};
    o_words[2] = {i_fields.order_id[7:0], 16'h0000, i_fields.time_stamp[31:24]};
    o_words[3] = {8'h00, i_fields.order_id[31:8]};

    // Body layout differs per type; the stock ID floats to different byte offsets.
    unique case (i_fields.order_type)
      ORD_ADD: begin
        o_words[4] = {7'h00, (i_fields.side == TRADE_SELL), 24'h000000};
        o_words[5] = i_fields.quantity;
        o_words[6] = sym_c[31:0];
        o_words[7] = sym_c[63:32];
        o_words[8] = i_fields.price;
      end
      ORD_CANCEL: begin
        o_words[4] = {sym_c[7:0], 24'h000000};
        o_words[5] = sym_c[39:8];
        o_words[6] = {8'h00, sym_c[63:40]};
      end
      ORD_EXECUTE: begin
        o_words[4] = {i_fields.quantity[7:0], 24'h000000};
        o_words[5] = {sym_c[7:0], i_fields.quantity[31:8]};
        o_words[6] = sym_c[39:8];
        o_words[7] = {8'h00, sym_c[63:40]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/order_msg_encoder.sv
// Accepts one order, buffers its packed message and streams nine words out
// under valid/ready backpressure; illegal order types are dropped with o_err.
module order_msg_encoder
  import order_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_order_type,
  input  logic [1:0]  i_stock_symbol,
  input  logic        i_trade_type,
  input  logic [31:0] i_order_id,
  input  logic [31:0] i_price,
  input  logic [31:0] i_quantity,
  input  logic [31:0] i_time,
  input  logic [15:0] i_locate_code,
  input  logic [15:0] i_tracking_number,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic [3:0]  o_word_idx,
  output logic        o_last,
  output logic        o_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t               state_q, state_d;
  msg_words_t           buf_q, buf_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [REG_WIDTH-1:0] word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  order_fields_t    fields_c;
  msg_words_t       packed_c;
  logic [IDX_W-1:0] idx_inc_c;

  always_comb begin
    fields_c.order_type = order_t'(i_order_type);
    fields_c.symbol     = stock_t'(i_stock_symbol);
    fields_c.side       = trade_t'(i_trade_type);
    fields_c.order_id   = i_order_id;
    fields_c.price      = i_price;
    fields_c.quantity   = i_quantity;
    fields_c.time_stamp = i_time;
    fields_c.locate     = i_locate_code;
    fields_c.tracking   = i_tracking_number;
  end

  order_msg_packer u_packer (
    .i_fields (fields_c),
    .o_words  (packed_c)
  );

  assign idx_inc_c = IDX_W'(idx_q + IDX_W'(1));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = valid_q;
    ready_d = ready_q;
    last_d  = last_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (order_t'(i_order_type) == ORD_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            buf_d   = packed_c;
            idx_d   = '0;
            word_d  = packed_c[0];
            valid_d = 1'b1;
            ready_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // Without a beat every output register simply holds.
        if (i_word_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            word_d  = '0;
            valid_d = 1'b0;
            ready_d = 1'b1;
            last_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d  = idx_inc_c;
            word_d = buf_q[idx_inc_c];
            last_d = (idx_inc_c == LAST_IDX);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_word_idx   = idx_q;
  assign o_last       = last_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_order_msg_encoder.sv
// Directed bench for order_msg_encoder: hand-computed message words, handshake
// timing, backpressure, illegal-type drop, mid-message reset and field loopback.
module tb_order_msg_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_order_type;
  logic [1:0]  i_stock_symbol;
  logic        i_trade_type;
  logic [31:0] i_order_id, i_price, i_quantity, i_time;
  logic [15:0] i_locate_code, i_tracking_number;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic [3:0]  o_word_idx;
  logic        o_last;
  logic        o_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  order_msg_encoder dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_order_type      (i_order_type),
    .i_stock_symbol    (i_stock_symbol),
    .i_trade_type      (i_trade_type),
    .i_order_id        (i_order_id),
    .i_price           (i_price),
    .i_quantity        (i_quantity),
    .i_time            (i_time),
    .i_locate_code     (i_locate_code),
    .i_tracking_number (i_tracking_number),
    .o_word            (o_word),
    .o_word_valid      (o_word_valid),
    .i_word_ready      (i_word_ready),
    .o_word_idx        (o_word_idx),
    .o_last            (o_last),
    .o_err             (o_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] typ, input logic [1:0] sym, input logic side,
                      input logic [31:0] id, input logic [31:0] price, input logic [31:0] qty,
                      input logic [31:0] ts, input logic [15:0] loc, input logic [15:0] trk);
    @(negedge i_clk);
    i_order_type = typ; i_stock_symbol = sym; i_trade_type = side;
    i_order_id = id; i_price = price; i_quantity = qty; i_time = ts;
    i_locate_code = loc; i_tracking_number = trk;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Collects nine beats; optionally stalls stall_n cycles at word stall_at.
  task automatic recv_msg(input string tag, input int stall_at, input int stall_n,
                          output logic [8:0][31:0] got, output int cycles);
    int k;
    int stalls;
    logic [31:0] held;
    k = 0; stalls = 0; cycles = 0; got = '0; held = '0;
    while (k < 9 && cycles < 60) begin
      cycles++;
      if (k == stall_at && stalls < stall_n) begin
        i_word_ready = 1'b0;
        if (stalls > 0) begin
          check($sformatf("%s_hold_word", tag), o_word, held);
          check($sformatf("%s_hold_idx", tag), o_word_idx, k);
        end
        check($sformatf("%s_busy_ready", tag), o_ready, 1'b0);
        held = o_word;
        stalls++;
      end else begin
        i_word_ready = 1'b1;
        if (o_word_valid) begin
          check($sformatf("%s_idx%0d", tag, k), o_word_idx, k);
          check($sformatf("%s_last%0d", tag, k), o_last, (k == 8));
          got[k] = o_word;
          k++;
        end
      end
      @(negedge i_clk);
    end
    i_word_ready = 1'b1;
    check($sformatf("%s_beats", tag), k, 9);
  endtask

  task automatic check_words(input string tag, input logic [8:0][31:0] got,
                             input logic [8:0][31:0] exp);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s_w%0d", tag, k), got[k], exp[k]);
  endtask

  // Independent parser-side decode of a message back to its fields.
  task automatic loopback(input string tag, input logic [8:0][31:0] w,
                          input logic [1:0] typ, input logic [1:0] sym, input logic side,
                          input logic [31:0] id, input logic [31:0] price, input logic [31:0] qty,
                          input logic [31:0] ts, input logic [15:0] loc, input logic [15:0] trk);
    logic [1:0]  t;
    logic [1:0]  sc;
    logic [63:0] s;
    case (w[0][7:0])
      8'h41:   t = 2'd0;
      8'h44:   t = 2'd1;
      8'h45:   t = 2'd2;
      default: t = 2'd3;
    endcase
    check({tag, "_type"}, t, typ);
    check({tag, "_loc"}, w[0][23:8], loc);
    check({tag, "_trk"}, {w[1][7:0], w[0][31:24]}, trk);
    check({tag, "_time"}, {w[2][7:0], w[1][31:8]}, ts);
    check({tag, "_id"}, {w[3][23:0], w[2][31:24]}, id);
    case (t)
      2'd0:    s = {w[7], w[6]};
      2'd1:    s = {w[6][23:0], w[5], w[4][31:24]};
      default: s = {w[7][23:0], w[6], w[5][31:24]};
    endcase
    case (s)
      64'h4141504C20202020: sc = 2'd0;
      64'h414D5A4E20202020: sc = 2'd1;
      64'h474F4F474C202020: sc = 2'd2;
      default:              sc = 2'd3;
    endcase
    check({tag, "_sym"}, sc, sym);
    if (typ == 2'd0) begin
      check({tag, "_side"}, w[4][24], side);
      check({tag, "_qty"}, w[5], qty);
      check({tag, "_price"}, w[8], price);
    end
    if (typ == 2'd2)
      check({tag, "_qty"}, {w[5][23:0], w[4][31:24]}, qty);
  endtask

  logic [8:0][31:0] got, w_add, w_can, w_exe, exp;
  int cycles;
  int n;

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_word_ready = 1'b1;
    i_order_type = '0; i_stock_symbol = '0; i_trade_type = 1'b0;
    i_order_id = '0; i_price = '0; i_quantity = '0; i_time = '0;
    i_locate_code = '0; i_tracking_number = '0;

    repeat (2) @(negedge i_clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_word_valid, 1'b0);
    check("rst_word", o_word, 32'h0);
    check("rst_idx", o_word_idx, 4'd0);
    check("rst_last", o_last, 1'b0);
    check("rst_err", o_err, 1'b0);
    i_rst_n = 1'b1;

    // ADD AAPL SELL, full latency check
    send(2'd0, 2'd0, 1'b1, 32'h12345678, 32'd1500, 32'd100, 32'hAABBCCDD, 16'h0102, 16'h0304);
    recv_msg("add", -1, 0, w_add, cycles);
    exp = {32'd1500, 32'h4141504C, 32'h20202020, 32'd100, 32'h01000000,
           32'h00123456, 32'h780000AA, 32'hBBCCDD03, 32'h04010241};
    check_words("add", w_add, exp);
    check("add_cycles", cycles, 9);
    check("add_ready_after", o_ready, 1'b1);
    check("add_valid_after", o_word_valid, 1'b0);

    // CANCEL MSFT: price, quantity and side must not leak
    send(2'd1, 2'd3, 1'b1, 32'd7, 32'hFFFF, 32'd55, 32'h0, 16'h0, 16'h0);
    recv_msg("can", -1, 0, w_can, cycles);
    exp = {32'h0, 32'h0, 32'h004D5346, 32'h54202020, 32'h20000000,
           32'h0, 32'h07000000, 32'h0, 32'h00000044};
    check_words("can", w_can, exp);

    // EXECUTE GOOGL
    send(2'd2, 2'd2, 1'b1, 32'hCAFEF00D, 32'd999, 32'h11223344, 32'h01020304, 16'hBEEF, 16'h5566);
    recv_msg("exe", -1, 0, w_exe, cycles);
    exp = {32'h0, 32'h00474F4F, 32'h474C2020, 32'h20112233, 32'h44000000,
           32'h00CAFEF0, 32'h0D000001, 32'h02030455, 32'h66BEEF45};
    check_words("exe", w_exe, exp);

    // Illegal type, back-to-back for two cycles
    @(negedge i_clk);
    i_order_type = 2'd3; i_valid = 1'b1;
    @(negedge i_clk);
    check("err_pulse1", o_err, 1'b1);
    check("err_no_valid", o_word_valid, 1'b0);
    check("err_ready", o_ready, 1'b1);
    @(negedge i_clk);
    check("err_pulse2", o_err, 1'b1);
    i_valid = 1'b0;
    @(negedge i_clk);
    check("err_clear", o_err, 1'b0);
    check("err_still_idle", o_word_valid, 1'b0);

    // ADD AMZN BUY after the drop, with a 3-cycle stall at word 4
    send(2'd0, 2'd1, 1'b0, 32'h1, 32'h10, 32'h20, 32'h0, 16'h0, 16'h0);
    recv_msg("bp", 4, 3, got, cycles);
    exp = {32'h10, 32'h414D5A4E, 32'h20202020, 32'h20, 32'h0,
           32'h0, 32'h01000000, 32'h0, 32'h00000041};
    check_words("bp", got, exp);
    check("bp_cycles", cycles, 12);
    check("bp_ready_after", o_ready, 1'b1);

    // Reset while word 5 is presented
    send(2'd0, 2'd0, 1'b1, 32'h12345678, 32'd1500, 32'd100, 32'hAABBCCDD, 16'h0102, 16'h0304);
    n = 0;
    while (o_word_idx != 4'd5 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("rst_mid_reach5", o_word_idx, 4'd5);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_valid", o_word_valid, 1'b0);
    check("rst_mid_ready", o_ready, 1'b1);
    check("rst_mid_last", o_last, 1'b0);
    check("rst_mid_idx", o_word_idx, 4'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_rel_ready", o_ready, 1'b1);
    check("rst_rel_valid", o_word_valid, 1'b0);
    send(2'd1, 2'd3, 1'b1, 32'd7, 32'hFFFF, 32'd55, 32'h0, 16'h0, 16'h0);
    recv_msg("post_rst", -1, 0, got, cycles);
    check_words("post_rst", got, w_can);
    exp = {32'h0, 32'h0, 32'h004D5346, 32'h54202020, 32'h20000000,
           32'h0, 32'h07000000, 32'h0, 32'h00000044};
    check_words("post_rst_exp", got, exp);

    // Parser-side loopback of all three types
    loopback("lb_add", w_add, 2'd0, 2'd0, 1'b1, 32'h12345678, 32'd1500, 32'd100,
             32'hAABBCCDD, 16'h0102, 16'h0304);
    loopback("lb_can", w_can, 2'd1, 2'd3, 1'b1, 32'd7, 32'hFFFF, 32'd55,
             32'h0, 16'h0, 16'h0);
    loopback("lb_exe", w_exe, 2'd2, 2'd2, 1'b1, 32'hCAFEF00D, 32'd999, 32'h11223344,
             32'h01020304, 16'hBEEF, 16'h5566);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/order_msg_encoder.md
# order_msg_encoder

Transmit-side counterpart of the order message parser: accepts one decoded order (type, symbol, id, price, quantity, side, time, locate, tracking), packs it into the nine-word 32-bit ITCH-style layout the parser consumes, and streams the words out one per beat under valid/ready backpressure. It sits between the strategy/order-generation logic and the outbound message path, and also feeds the parser in loopback testing.

## Interface
- REG_WIDTH, 32: word width; the packing below is defined only for 32.
- NUM_WORDS, 9: words per message, always emitted for every type.
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  order fields valid.
- o_ready  out  1  encoder can accept an order.
- i_order_type  in  2  0 ADD, 1 CANCEL, 2 EXECUTE, 3 illegal.
- i_stock_symbol  in  2  0 AAPL, 1 AMZN, 2 GOOGL, 3 MSFT.
- i_trade_type  in  1  0 BUY, 1 SELL (ADD only).
- i_order_id, i_price, i_quantity, i_time  in  32 each.
- i_locate_code, i_tracking_number  in  16 each.
- o_word  out  32  current message word.
- o_word_valid  out  1  o_word valid.
- i_word_ready  in  1  downstream accepts o_word.
- o_word_idx  out  4  index 0..8 of o_word.
- o_last  out  1  high with word 8.
- o_err  out  1  one-cycle pulse: illegal type accepted and dropped.

## Operation
- States: IDLE, SEND. Reset: IDLE, o_ready=1, o_word_valid=0, o_word=0, o_word_idx=0, o_last=0, o_err=0, buffer all zero.
- IDLE: o_ready=1. On i_valid: type 0..2 -> packed words registered into buffer, idx=0, go SEND. Type 3 -> o_err=1 next cycle, stay IDLE, nothing emitted.
- SEND: o_ready=0, o_word_valid=1, o_word=buffer[idx]. On i_word_ready: idx<8 -> idx+1; idx=8 -> IDLE, idx=0. No beat -> o_word, o_word_idx, o_last held stable.
- Stock ID S (64-bit ASCII, space-padded): AAPL 0x4141504C20202020, AMZN 0x414D5A4E20202020, GOOGL 0x474F4F474C202020, MSFT 0x4D53465420202020.
- Common: w0[7:0]=type char ('A' 0x41, 'D' 0x44, 'E' 0x45); w0[23:8]=locate; w0[31:24]=tracking[7:0]; w1[7:0]=tracking[15:8]; w1[31:8]=time[23:0]; w2[7:0]=time[31:24]; w2[23:8]=0; w2[31:24]=id[7:0]; w3[23:0]=id[31:8]; w3[31:24]=0; w4[23:0]=0.
- ADD: w4[31:24]=0x00 buy / 0x01 sell; w5=quantity; w6=S[31:0]; w7=S[63:32]; w8=price.
- CANCEL: w4[31:24]=S[7:0]; w5=S[39:8]; w6[23:0]=S[63:40]; w6[31:24]=0; w7=w8=0. Price, quantity, side ignored.
- EXECUTE: w4[31:24]=quantity[7:0]; w5[23:0]=quantity[31:8]; w5[31:24]=S[7:0]; w6=S[39:8]; w7[23:0]=S[63:40]; w7[31:24]=0; w8=0. Price, side ignored.
- All unlisted bits 0. No arithmetic; fields truncated/zero-extended exactly as listed.

## Timing
- Input handshake: i_valid & o_ready at edge. Word 0 valid the next cycle.
- Output beat: o_word_valid & i_word_ready at edge. i_word_ready held high -> 9 consecutive beats.
- Message latency with no backpressure: accept at cycle N, word k on cycle N+1+k, o_last at N+9, o_ready high at N+10. Max throughput: one message per 10 cycles.
- i_valid while o_ready=0 ignored; fields not captured, upstream must hold.
- i_word_ready with o_word_valid=0 has no effect.
- Async reset mid-SEND: outputs to reset values immediately, partial message abandoned, no o_last; next message restarts at word 0.
- o_err pulses exactly one cycle per illegal order; back-to-back illegal orders give back-to-back pulses.

## Structure
- Shared package order_pkg: order_t, trade_t, stock_t enums; type chars 'A'/'D'/'E'; four stock-ID constants; NUM_WORDS. Parser migrates to the same package.
- Sub-module order_msg_packer: purely combinational fields -> 9x32 word array. Encoder owns FSM, buffer, index counter. Packer reused by testbench golden model.

## Test plan
- ADD, AAPL, SELL, id 0x12345678, price 1500, qty 100, time 0xAABBCCDD, locate 0x0102, tracking 0x0304, ready high -> w0=0x04010241, w1=0xBBCCDD03, w2=0x780000AA, w3=0x00123456, w4=0x01000000, w5=100, w6=0x20202020, w7=0x4141504C, w8=1500; o_last with w8 only.
- CANCEL MSFT id 7, locate/tracking/time 0 -> w0=0x00000044, w2=0x07000000, w4=0x20000000, w5=0x54202020, w6=0x004D5346, w7=w8=0.
- EXECUTE GOOGL qty 0x11223344 -> w4=0x44000000, w5=0x20112233, w6=0x474C2020, w7=0x00474F4F, w8=0.
- Backpressure: i_word_ready low 3 cycles at idx 4 -> o_word/o_word_idx frozen, o_ready low; completes in 13 cycles after accept.
- Type 3 -> o_err one cycle, no o_word_valid, o_ready stays 1; next valid ADD encodes correctly.
- Reset asserted at idx 5 -> o_word_valid=0 immediately, o_ready=1 after release; loopback into parser reproduces all three order types' fields exactly.
